// File: rtl/led_pwm_fader_if.sv
// rtl/led_pwm_fader_if.sv - visualizer-to-fader pattern/control bundle and LED drive outputs
//
// Purpose: groups the LED request pattern, fader controls and the PWM/status outputs.
// Signals:
//   led_req        8   LED on/off pattern, bit i requests LED i
//   enable         1   1 = follow led_req, 0 = fade everything out
//   brightness_max 8   ceiling for every LED level
//   led_pwm        8   registered PWM drive to the LED pins
//   led_state      16  per-LED state, bits [2i+1:2i]: 00 OFF, 01 RISE, 10 ON, 11 FALL
//   frame_tick     1   one-cycle pulse when the PWM frame wraps
// Modports: master drives the pattern/controls, slave is the fader.
interface led_pwm_fader_if;
    logic [7:0]  led_req;
    logic        enable;
    logic [7:0]  brightness_max;
    logic [7:0]  led_pwm;
    logic [15:0] led_state;
    logic        frame_tick;

    modport master (
        output led_req, enable, brightness_max,
        input  led_pwm, led_state, frame_tick
    );

    modport slave (
        input  led_req, enable, brightness_max,
        output led_pwm, led_state, frame_tick
    );
endinterface

// File: rtl/led_pwm_fader.sv
// rtl/led_pwm_fader.sv - 8-channel LED attack/release fader with frame-synchronous PWM
//
// Purpose: turns an on/off LED pattern into smoothly ramped PWM brightness.
// Ports:
//   sys_clk  in  system clock
//   rst      in  asynchronous active-high reset
//   bus      slave modport of led_pwm_fader_if (pattern/controls in, PWM/state/frame out)
module led_pwm_fader #(
    parameter int FADE_DIV     = 50000,
    parameter int ATTACK_STEP  = 32,
    parameter int RELEASE_STEP = 4,
    parameter int GAMMA_EN     = 1
) (
    input  logic            sys_clk,
    input  logic            rst,
    led_pwm_fader_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_RISE = 2'b01,
        ST_ON   = 2'b10,
        ST_FALL = 2'b11
    } led_state_t;

    localparam int         FADE_W  = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
    localparam logic [7:0] ATK     = 8'(ATTACK_STEP);
    localparam logic [7:0] REL     = 8'(RELEASE_STEP);
    localparam logic [7:0] PWM_TOP = 8'd254;

    logic [7:0]        req_q, req_d;
    logic [FADE_W-1:0] fade_cnt_q, fade_cnt_d;
    logic [7:0]        pwm_cnt_q, pwm_cnt_d;
    logic [7:0]        led_pwm_q, led_pwm_d;
    logic [7:0]        level_q [8];
    logic [7:0]        level_d [8];
    logic [7:0]        duty_q [8];
    logic [7:0]        duty_d [8];
    led_state_t        state_q [8];
    led_state_t        state_d [8];

    logic              fade_tick;
    logic              pwm_wrap;
    logic [7:0]        target;
    logic [15:0]       led_state_w;

    assign fade_tick = (fade_cnt_q == FADE_W'(FADE_DIV - 1));
    assign pwm_wrap  = (pwm_cnt_q == PWM_TOP);
    assign target    = bus.brightness_max;

    // One fade step; the attack sum is 9 bits so a large step near 255 saturates at the target.
    function automatic logic [7:0] step_level(input logic req, input logic [7:0] lvl,
                                              input logic [7:0] tgt);
        logic [8:0] sum;
        sum = {1'b0, lvl} + {1'b0, ATK};
        if (!req)
            return (lvl > REL) ? (lvl - REL) : 8'd0;
        else if (lvl < tgt)
            return (sum > {1'b0, tgt}) ? tgt : sum[7:0];
        else if (lvl > tgt)
            return ((lvl - tgt) > REL) ? (lvl - REL) : tgt;
        else
            return lvl;
    endfunction

    // State is derived from the post-update level, so a zero target with req held reads ON.
    function automatic led_state_t classify(input logic req, input logic [7:0] lvl,
                                            input logic [7:0] tgt);
        if (!req)
            return (lvl == 8'd0) ? ST_OFF : ST_FALL;
        else if (lvl < tgt)
            return ST_RISE;
        else if (lvl == tgt)
            return ST_ON;
        else
            return ST_FALL;
    endfunction

    // Square law via the top byte of level^2; full scale is pinned so 255 stays always-on.
    function automatic logic [7:0] gamma(input logic [7:0] lvl);
        logic [15:0] prod;
        prod = {8'd0, lvl} * {8'd0, lvl};
        if (GAMMA_EN == 0)
            return lvl;
        else if (lvl == 8'hFF)
            return 8'hFF;
        else
            return prod[15:8];
    endfunction

    always_comb begin
        req_d      = bus.led_req & {8{bus.enable}};
        fade_cnt_d = fade_tick ? '0 : fade_cnt_q + FADE_W'(1);
        pwm_cnt_d  = pwm_wrap ? 8'd0 : pwm_cnt_q + 8'd1;
        led_pwm_d  = '0;
        for (int i = 0; i < 8; i++) begin
            level_d[i]   = level_q[i];
            state_d[i]   = state_q[i];
            duty_d[i]    = duty_q[i];
            led_pwm_d[i] = (duty_q[i] > pwm_cnt_q);
            if (fade_tick) begin
                level_d[i] = step_level(req_q[i], level_q[i], target);
                state_d[i] = classify(req_q[i], level_d[i], target);
            end
            // level_q is the pre-tick value, so a coincident fade tick is seen next frame.
            if (pwm_wrap)
                duty_d[i] = gamma(level_q[i]);
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            req_q      <= '0;
            fade_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            led_pwm_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                level_q[i] <= '0;
                duty_q[i]  <= '0;
                state_q[i] <= ST_OFF;
            end
        end else begin
            req_q      <= req_d;
            fade_cnt_q <= fade_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            led_pwm_q  <= led_pwm_d;
            for (int i = 0; i < 8; i++) begin
                level_q[i] <= level_d[i];
                duty_q[i]  <= duty_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        led_state_w = '0;
        for (int i = 0; i < 8; i++)
            led_state_w[2*i +: 2] = state_q[i];
    end

    assign bus.led_pwm    = led_pwm_q;
    assign bus.led_state  = led_state_w;
    assign bus.frame_tick = pwm_wrap;

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb/tb_led_pwm_fader.sv - directed self-checking bench for led_pwm_fader
module tb_led_pwm_fader;

    logic       sys_clk = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] led_req = 8'h00;
    logic       enable  = 1'b0;
    logic [7:0] bm      = 8'h00;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 sys_clk = ~sys_clk;

    led_pwm_fader_if bus_g ();
    led_pwm_fader_if bus_l ();

    assign bus_g.led_req        = led_req;
    assign bus_g.enable         = enable;
    assign bus_g.brightness_max = bm;
    assign bus_l.led_req        = led_req;
    assign bus_l.enable         = enable;
    assign bus_l.brightness_max = bm;

    led_pwm_fader #(.FADE_DIV(4), .ATTACK_STEP(32), .RELEASE_STEP(4), .GAMMA_EN(1)) dut_g (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus_g)
    );

    led_pwm_fader #(.FADE_DIV(4), .ATTACK_STEP(32), .RELEASE_STEP(4), .GAMMA_EN(0)) dut_l (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus_l)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge just after the next fade-tick update.
    task automatic wait_tick();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (dut_g.fade_tick) begin
                @(negedge sys_clk);
                seen = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        if (!seen) expect_eq("tick_timeout", 32'd0, 32'd1);
    endtask

    // Always advances at least one cycle; returns at a negedge with frame_tick high.
    task automatic wait_frame();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge sys_clk);
            if (bus_g.frame_tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) expect_eq("frame_timeout", 32'd0, 32'd1);
    endtask

    // Input changes land right after a tick so the next tick sees them registered.
    task automatic apply(input logic [7:0] req, input logic en, input logic [7:0] b);
        wait_tick();
        led_req = req;
        enable  = en;
        bm      = b;
        @(negedge sys_clk);
    endtask

    task automatic count_high(output int hg, output int hl);
        hg = 0;
        hl = 0;
        for (int k = 0; k < 255; k++) begin
            @(negedge sys_clk);
            if (bus_g.led_pwm[0]) hg++;
            if (bus_l.led_pwm[0]) hl++;
        end
    endtask

    initial begin
        int lvl;
        int ticks;
        int hg;
        int hl;
        int gap;
        logic [1:0] st;

        // Reset state
        led_req = 8'h01;
        enable  = 1'b1;
        bm      = 8'hFF;
        repeat (3) @(negedge sys_clk);
        expect_eq("rst_pwm", 32'(bus_g.led_pwm), 32'h0);
        expect_eq("rst_state", 32'(bus_g.led_state), 32'h0);
        expect_eq("rst_frame", 32'(bus_g.frame_tick), 32'h0);
        expect_eq("rst_level", 32'(dut_g.level_q[0]), 32'h0);
        rst = 1'b0;

        // Reset mid-ramp at level 96
        for (int t = 1; t <= 3; t++) begin
            wait_tick();
            expect_eq("pre_rst_level", 32'(dut_g.level_q[0]), 32'(t * 32));
        end
        #2 rst = 1'b1;
        #1;
        expect_eq("midrst_pwm", 32'(bus_g.led_pwm), 32'h0);
        expect_eq("midrst_state", 32'(bus_g.led_state), 32'h0);
        expect_eq("midrst_level", 32'(dut_g.level_q[0]), 32'h0);
        @(negedge sys_clk);
        rst = 1'b0;

        // Attack ramp 32..224, 255 then constant-on PWM
        lvl = 0;
        for (int t = 0; t < 8; t++) begin
            wait_tick();
            lvl = (lvl + 32 > 255) ? 255 : lvl + 32;
            st  = (lvl < 255) ? 2'b01 : 2'b10;
            expect_eq("attack_level", 32'(dut_g.level_q[0]), 32'(lvl));
            expect_eq("attack_state", 32'(bus_g.led_state), {30'd0, st});
        end
        wait_frame();
        @(negedge sys_clk);
        count_high(hg, hl);
        expect_eq("full_on_high", 32'(hg), 32'd255);

        // Release from 255 with no underflow
        apply(8'h00, 1'b1, 8'hFF);
        lvl   = 255;
        ticks = 0;
        for (int t = 0; t < 80 && lvl > 0; t++) begin
            wait_tick();
            lvl = (lvl > 4) ? lvl - 4 : 0;
            ticks++;
            st  = (lvl > 0) ? 2'b11 : 2'b00;
            expect_eq("release_level", 32'(dut_g.level_q[0]), 32'(lvl));
            expect_eq("release_state", 32'(bus_g.led_state), {30'd0, st});
        end
        expect_eq("release_ticks", 32'(ticks), 32'd64);
        wait_tick();
        expect_eq("floor_level", 32'(dut_g.level_q[0]), 32'h0);
        expect_eq("floor_state", 32'(bus_g.led_state), 32'h0);

        // Level held at 128: duty 128 linear, 64 with gamma; frame period 255
        apply(8'h01, 1'b1, 8'd128);
        for (int t = 1; t <= 4; t++) begin
            wait_tick();
            st = (t < 4) ? 2'b01 : 2'b10;
            expect_eq("hold_level", 32'(dut_g.level_q[0]), 32'(t * 32));
            expect_eq("hold_state", 32'(bus_g.led_state), {30'd0, st});
        end
        wait_frame();
        @(negedge sys_clk);
        count_high(hg, hl);
        expect_eq("gamma_high", 32'(hg), 32'd64);
        expect_eq("linear_high", 32'(hl), 32'd128);
        wait_frame();
        gap = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge sys_clk);
            if (bus_g.frame_tick) begin
                gap = k;
                break;
            end
        end
        expect_eq("frame_period", 32'(gap), 32'd255);

        // All LEDs to 255, then ceiling lowered to 100
        apply(8'hFF, 1'b1, 8'hFF);
        repeat (9) wait_tick();
        expect_eq("all_on_state", 32'(bus_g.led_state), 32'hAAAA);
        expect_eq("all_on_level7", 32'(dut_g.level_q[7]), 32'd255);
        apply(8'hFF, 1'b1, 8'd100);
        lvl   = 255;
        ticks = 0;
        for (int t = 0; t < 50 && lvl > 100; t++) begin
            wait_tick();
            lvl = (lvl - 100 > 4) ? lvl - 4 : 100;
            ticks++;
            expect_eq("ceil_level0", 32'(dut_g.level_q[0]), 32'(lvl));
            expect_eq("ceil_level5", 32'(dut_g.level_q[5]), 32'(lvl));
            expect_eq("ceil_state", 32'(bus_g.led_state), (lvl > 100) ? 32'hFFFF : 32'hAAAA);
        end
        expect_eq("ceil_ticks", 32'(ticks), 32'd39);
        repeat (2) wait_tick();
        expect_eq("ceil_hold", 32'(dut_g.level_q[3]), 32'd100);

        // enable low fades everything out, enable high rises again
        apply(8'hFF, 1'b0, 8'd100);
        lvl = 100;
        for (int t = 0; t < 30 && lvl > 0; t++) begin
            wait_tick();
            lvl = (lvl > 4) ? lvl - 4 : 0;
            expect_eq("dis_level6", 32'(dut_g.level_q[6]), 32'(lvl));
            expect_eq("dis_state", 32'(bus_g.led_state), (lvl > 0) ? 32'hFFFF : 32'h0000);
        end
        apply(8'hFF, 1'b1, 8'd100);
        expect_eq("reen_still_off", 32'(bus_g.led_state), 32'h0000);
        wait_tick();
        expect_eq("reen_level", 32'(dut_g.level_q[2]), 32'd32);
        expect_eq("reen_state", 32'(bus_g.led_state), 32'h5555);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
